// File: rtl/leds7_display_ctrl.sv
// Multi-digit seven-segment display controller: binary word in over valid/ready,
// decimal (double-dabble) or hexadecimal digits out, with blanking and overflow dashes.
module leds7_display_ctrl #(
    parameter int DIGITS         = 4,
    parameter int BIN_WIDTH      = 14,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIN_WIDTH-1:0]   in_data,
    input  logic                   in_hex,
    input  logic                   blank_lz,
    output logic [7*DIGITS-1:0]    seg_out,
    output logic                   overflow,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        pow10 = 64'd1;
        for (int k = 0; k < n; k++) begin
            pow10 = pow10 * 64'd10;
        end
    endfunction

    localparam int BCD_DIGITS = (BIN_WIDTH + 2) / 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int PAD_DIGITS = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
    localparam int PAD_W      = 4 * PAD_DIGITS;
    localparam int HEX_W      = 4 * DIGITS;
    localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0]    LAST     = CNT_W'(BIN_WIDTH - 1);
    localparam logic [63:0]         DEC_MAX  = pow10(DIGITS) - 64'd1;
    localparam logic [6:0]          SEG_DASH = 7'b0000001;
    localparam logic [6:0]          SEG_OFF  = 7'b0000000;
    localparam logic [7*DIGITS-1:0] POL_MASK = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'h0: encode = 7'b1111110;
            4'h1: encode = 7'b0110000;
            4'h2: encode = 7'b1101101;
            4'h3: encode = 7'b1111001;
            4'h4: encode = 7'b0110011;
            4'h5: encode = 7'b1011011;
            4'h6: encode = 7'b1011111;
            4'h7: encode = 7'b1110000;
            4'h8: encode = 7'b1111111;
            4'h9: encode = 7'b1110011;
            4'hA: encode = 7'b1110111;
            4'hB: encode = 7'b0011111;
            4'hC: encode = 7'b1001110;
            4'hD: encode = 7'b0111101;
            4'hE: encode = 7'b1001111;
            default: encode = 7'b1000111;
        endcase
    endfunction

    state_t                 state, next_state;
    logic [BIN_WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]       bcd_q, bcd_adj;
    logic                   hex_q, blank_q, ovf_q;
    logic [CNT_W-1:0]       cnt;
    logic [63:0]            data_ext;
    logic                   accept_ovf;
    logic [PAD_W-1:0]       src;
    logic [3:0]             nib;
    logic                   seen;
    logic [7*DIGITS-1:0]    seg_next;

    // Handshake: a word transfers on a rising edge with in_valid & in_ready; in_ready
    // is high only in IDLE, and in_valid outside IDLE is ignored (no queuing).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = (state == IDLE);
        case (state)
            IDLE:    if (in_valid) next_state = in_hex ? UPDATE : CONVERT;
            CONVERT: if (cnt == LAST) next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign dbg_state = state;

    assign data_ext   = 64'(in_data);
    assign accept_ovf = in_hex ? ((data_ext >> HEX_W) != 64'd0) : (data_ext > DEC_MAX);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Digits above the display are zero unless overflowed, so they seed the blanking scan.
    always_comb begin
        src      = hex_q ? PAD_W'(bin_q) : PAD_W'(bcd_q);
        seen     = |(src >> HEX_W);
        seg_next = '0;
        nib      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = src[4*i +: 4];
            if (ovf_q)
                seg_next[7*i +: 7] = SEG_DASH;
            else if (blank_q && !seen && nib == 4'd0 && i != 0)
                seg_next[7*i +: 7] = SEG_OFF;
            else
                seg_next[7*i +: 7] = encode(nib);
            if (nib != 4'd0) seen = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            hex_q    <= 1'b0;
            blank_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt      <= '0;
            seg_out  <= POL_MASK;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_q   <= in_data;
                        bcd_q   <= '0;
                        hex_q   <= in_hex;
                        blank_q <= blank_lz;
                        ovf_q   <= accept_ovf;
                        cnt     <= '0;
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt            <= cnt + 1'b1;
                end
                UPDATE: begin
                    seg_out  <= seg_next ^ POL_MASK;
                    overflow <= ovf_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leds7_display_ctrl.sv
// Bench for leds7_display_ctrl: directed and random words against an arithmetic
// model of the display; an active-low instance shares the stimulus.
module tb_leds7_display_ctrl;

    localparam int DIGITS = 4;
    localparam int BW     = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_hex;
    logic          blank_lz;
    logic          in_ready, in_ready_n;
    logic [27:0]   seg_out, seg_out_n;
    logic          overflow, overflow_n;
    logic [1:0]    dbg_state, dbg_state_n;

    int vectors     = 0;
    int miscompares = 0;
    logic [27:0] cur_seg;

    localparam logic [6:0] ENC [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    leds7_display_ctrl #(.DIGITS(DIGITS), .BIN_WIDTH(BW), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_hex(in_hex), .blank_lz(blank_lz),
        .seg_out(seg_out), .overflow(overflow), .dbg_state(dbg_state)
    );

    leds7_display_ctrl #(.DIGITS(DIGITS), .BIN_WIDTH(BW), .SEG_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_data(in_data), .in_hex(in_hex), .blank_lz(blank_lz),
        .seg_out(seg_out_n), .overflow(overflow_n), .dbg_state(dbg_state_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_display(input string tag, input logic [27:0] exp_seg, input logic exp_ovf);
        logic [27:0] inv;
        inv = ~exp_seg;
        check({tag, "_seg"}, seg_out, exp_seg);
        check({tag, "_seg_active_low"}, seg_out_n, inv);
        check({tag, "_overflow"}, overflow, exp_ovf);
        check({tag, "_overflow_active_low"}, overflow_n, exp_ovf);
    endtask

    // Display model from the rules: digit values by division or nibble extraction.
    function automatic void model(input int unsigned v, input bit hex, input bit blk,
                                  output logic [27:0] seg, output logic ovf);
        int unsigned d[4];
        int unsigned p;
        int msd;
        ovf = hex ? (v > 32'hFFFF) : (v > 9999);
        msd = 0;
        p   = 1;
        for (int i = 0; i < 4; i++) begin
            d[i] = hex ? ((v >> (4 * i)) & 15) : ((v / p) % 10);
            p    = p * 10;
            if (d[i] != 0) msd = i;
        end
        seg = '0;
        for (int i = 0; i < 4; i++) begin
            if (ovf)             seg[7*i +: 7] = 7'b0000001;
            else if (blk && i > msd) seg[7*i +: 7] = 7'b0000000;
            else                 seg[7*i +: 7] = ENC[d[i]];
        end
    endfunction

    task automatic send(input string tag, input int unsigned v, input bit hex,
                        input bit blk, input bit noise);
        logic [27:0] es;
        logic        eo;
        int          lat, low, hold_bad;
        model(v, hex, blk, es, eo);
        lat = hex ? 1 : BW + 1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = BW'(v);
        in_hex   = hex;
        blank_lz = blk;
        check({tag, "_ready_before"}, in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        low      = in_ready ? 0 : 1;
        hold_bad = 0;
        in_valid = noise;
        in_data  = BW'($urandom);
        in_hex   = 1'($urandom_range(0, 1));
        blank_lz = 1'($urandom_range(0, 1));
        for (int k = 1; k < lat; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!in_ready) low++;
            if (seg_out !== cur_seg) hold_bad++;
            in_data = BW'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_ready_low_cycles"}, low, lat);
        check({tag, "_hold"}, hold_bad, 0);
        check({tag, "_ready_after"}, in_ready, 1'b1);
        check_display(tag, es, eo);
        cur_seg = es;
    endtask

    initial begin
        int unsigned v;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_hex   = 1'b0;
        blank_lz = 1'b0;
        cur_seg  = '0;

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            in_hex   = 1'($urandom_range(0, 1));
            blank_lz = 1'($urandom_range(0, 1));
            check("reset_ready", in_ready, 1'b1);
            check_display("reset", 28'h0, 1'b0);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_ready", in_ready, 1'b1);
        check_display("release", 28'h0, 1'b0);

        send("dec_1234", 1234, 1'b0, 1'b0, 1'b0);
        send("dec_7_blank", 7, 1'b0, 1'b1, 1'b0);
        send("dec_7_noblank", 7, 1'b0, 1'b0, 1'b0);
        send("dec_0_blank", 0, 1'b0, 1'b1, 1'b0);
        send("dec_10000", 10000, 1'b0, 1'b1, 1'b0);
        send("dec_9999", 9999, 1'b0, 1'b0, 1'b0);
        send("hex_2bad", 16'h2BAD, 1'b1, 1'b0, 1'b0);
        send("dec_6", 6, 1'b0, 1'b1, 1'b0);
        send("hex_0_blank", 0, 1'b1, 1'b1, 1'b1);
        send("dec_16383", 16383, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of converting 4321.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = BW'(4321);
        in_hex   = 1'b0;
        blank_lz = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_ready", in_ready, 1'b1);
        check_display("midreset", 28'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cur_seg = '0;
        send("dec_56_after_reset", 56, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
            send("random", v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
